// File: rtl/fib_mem_ctrl_pkg.sv
// Shared types and default memory map for the Fibonacci memory controller.
package fib_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_T1,
        RD_T2,
        CALC,
        WR_SUM,
        WR_T1,
        WR_T2,
        DONE
    } fib_state_t;

    localparam logic [7:0] DEF_ADDR_T1  = 8'd0;
    localparam logic [7:0] DEF_ADDR_T2  = 8'd1;
    localparam logic [7:0] DEF_ADDR_SUM = 8'd2;

endpackage

// File: rtl/fib_mem_ctrl_if.sv
// Data-memory bus between the Fibonacci controller and a synchronous-read memory.
interface fib_mem_ctrl_if;

    logic [7:0] endereco;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] dado_w;
    logic [7:0] dado_r;

    modport master (
        output endereco,
        output MemRead,
        output MemWrite,
        output dado_w,
        input  dado_r
    );

    modport slave (
        input  endereco,
        input  MemRead,
        input  MemWrite,
        input  dado_w,
        output dado_r
    );

endinterface

// File: rtl/fib_mem_ctrl.sv
// Fibonacci sequencer: reads t1/t2 from data memory, emits t1, writes back sum, t2, sum.
module fib_mem_ctrl
    import fib_mem_ctrl_pkg::*;
#(
    parameter logic [7:0] ADDR_T1  = DEF_ADDR_T1,
    parameter logic [7:0] ADDR_T2  = DEF_ADDR_T2,
    parameter logic [7:0] ADDR_SUM = DEF_ADDR_SUM
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           n,
    fib_mem_ctrl_if.master       bus,
    output logic [7:0]           term,
    output logic                 term_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    fib_state_t state;
    logic [7:0] t1;
    logic [7:0] t2;
    logic [7:0] sum;
    logic [7:0] i;
    logic [7:0] n_q;
    logic [8:0] sum_next;
    logic       last_term;

    // t2 arrives on dado_r during CALC, so the sum is formed straight from the bus.
    always_comb begin
        sum_next  = {1'b0, t1} + {1'b0, bus.dado_r};
        last_term = ({1'b0, i} + 9'd1) == {1'b0, n_q};
    end

    // Outputs are set on the edge entering each state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            t1           <= '0;
            t2           <= '0;
            sum          <= '0;
            i            <= '0;
            n_q          <= '0;
            bus.endereco <= '0;
            bus.MemRead  <= 1'b0;
            bus.MemWrite <= 1'b0;
            bus.dado_w   <= '0;
            term         <= '0;
            term_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            bus.MemRead  <= 1'b0;
            bus.MemWrite <= 1'b0;
            term_valid   <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        if (n != '0) begin
                            n_q          <= n;
                            i            <= '0;
                            busy         <= 1'b1;
                            bus.endereco <= ADDR_T1;
                            bus.MemRead  <= 1'b1;
                            state        <= RD_T1;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RD_T1: begin
                    bus.endereco <= ADDR_T2;
                    bus.MemRead  <= 1'b1;
                    state        <= RD_T2;
                end
                RD_T2: begin
                    t1         <= bus.dado_r;
                    term       <= bus.dado_r;
                    term_valid <= 1'b1;
                    state      <= CALC;
                end
                CALC: begin
                    t2           <= bus.dado_r;
                    sum          <= sum_next[7:0];
                    overflow     <= overflow | sum_next[8];
                    bus.endereco <= ADDR_SUM;
                    bus.dado_w   <= sum_next[7:0];
                    bus.MemWrite <= 1'b1;
                    state        <= WR_SUM;
                end
                WR_SUM: begin
                    bus.endereco <= ADDR_T1;
                    bus.dado_w   <= t2;
                    bus.MemWrite <= 1'b1;
                    state        <= WR_T1;
                end
                WR_T1: begin
                    bus.endereco <= ADDR_T2;
                    bus.dado_w   <= sum;
                    bus.MemWrite <= 1'b1;
                    state        <= WR_T2;
                end
                WR_T2: begin
                    if (last_term) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i            <= i + 8'd1;
                        bus.endereco <= ADDR_T1;
                        bus.MemRead  <= 1'b1;
                        state        <= RD_T1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_mem_ctrl.sv
// Directed bench for fib_mem_ctrl against a synchronous-read data memory model.
module tb_fib_mem_ctrl;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] n;
    logic [7:0] term;
    logic       term_valid;
    logic       busy;
    logic       done;
    logic       overflow;

    fib_mem_ctrl_if bus ();

    fib_mem_ctrl #(
        .ADDR_T1  (8'd0),
        .ADDR_T2  (8'd1),
        .ADDR_SUM (8'd2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .n          (n),
        .bus        (bus.master),
        .term       (term),
        .term_valid (term_valid),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    logic [7:0]  mem [256];
    logic [7:0]  rdata;
    logic [7:0]  terms [$];
    int unsigned checks;
    int unsigned errors;
    int unsigned overlap;
    int unsigned nreads;
    int unsigned nwrites;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.MemRead)  rdata <= mem[bus.endereco];
        if (bus.MemWrite) mem[bus.endereco] <= bus.dado_w;
    end
    assign bus.dado_r = rdata;

    always @(negedge clock) begin
        if (bus.MemRead && bus.MemWrite) overlap++;
        if (bus.MemRead)  nreads++;
        if (bus.MemWrite) nwrites++;
        if (term_valid)   terms.push_back(term);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
    endtask

    task automatic start_seq(input logic [7:0] nv);
        @(negedge clock);
        start = 1'b1;
        n     = nv;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit, output int unsigned cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= limit) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        check({tag, "_m0"}, {24'd0, mem[0]}, {24'd0, a});
        check({tag, "_m1"}, {24'd0, mem[1]}, {24'd0, b});
        check({tag, "_m2"}, {24'd0, mem[2]}, {24'd0, c});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        int unsigned rd0;
        int unsigned wr0;
        int unsigned hits;
        logic [7:0]  exp5 [5];
        checks  = 0;
        errors  = 0;
        overlap = 0;
        nreads  = 0;
        nwrites = 0;
        rdata   = '0;
        reset_n = 1'b0;
        start   = 1'b0;
        n       = '0;
        exp5    = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};

        repeat (3) @(negedge clock);
        check("rst_addr",  {24'd0, bus.endereco}, 32'd0);
        check("rst_rd",    {31'd0, bus.MemRead},  32'd0);
        check("rst_wr",    {31'd0, bus.MemWrite}, 32'd0);
        check("rst_wdata", {24'd0, bus.dado_w},   32'd0);
        check("rst_term",  {24'd0, term},         32'd0);
        check("rst_tv",    {31'd0, term_valid},   32'd0);
        check("rst_busy",  {31'd0, busy},         32'd0);
        check("rst_done",  {31'd0, done},         32'd0);
        check("rst_ovf",   {31'd0, overflow},     32'd0);
        reset_n = 1'b1;

        // Five terms from 0,1
        preload(8'd0, 8'd1, 8'd2);
        terms.delete();
        start_seq(8'd5);
        check("n5_busy_rise", {31'd0, busy}, 32'd1);
        wait_done(100, cyc);
        check("n5_latency", cyc, 32'd30);
        check("n5_busy_at_done", {31'd0, busy}, 32'd0);
        check("n5_count", terms.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < terms.size()) check($sformatf("n5_term%0d", k), {24'd0, terms[k]}, {24'd0, exp5[k]});
        @(negedge clock);
        check("n5_done_pulse", {31'd0, done}, 32'd0);
        check_mem("n5", 8'd5, 8'd8, 8'd8);
        check("n5_ovf", {31'd0, overflow}, 32'd0);

        // Single term with carry out of 8 bits
        preload(8'd200, 8'd100, 8'd0);
        terms.delete();
        start_seq(8'd1);
        wait_done(20, cyc);
        check("n1_latency", cyc, 32'd6);
        check("n1_count", terms.size(), 32'd1);
        if (terms.size() > 0) check("n1_term", {24'd0, terms[0]}, 32'd200);
        check("n1_ovf", {31'd0, overflow}, 32'd1);
        @(negedge clock);
        check_mem("n1", 8'd100, 8'd44, 8'd44);
        check("n1_ovf_sticky", {31'd0, overflow}, 32'd1);

        // n = 0: immediate done, no memory traffic
        terms.delete();
        rd0 = nreads;
        wr0 = nwrites;
        start_seq(8'd0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("n0_done_pulse", {31'd0, done}, 32'd0);
        check("n0_reads", nreads - rd0, 32'd0);
        check("n0_writes", nwrites - wr0, 32'd0);
        check("n0_terms", terms.size(), 32'd0);

        // Restart attempt mid-sequence is ignored
        preload(8'd0, 8'd1, 8'd2);
        terms.delete();
        start_seq(8'd3);
        repeat (4) @(negedge clock);
        start = 1'b1;
        n     = 8'd9;
        @(negedge clock);
        start = 1'b0;
        n     = 8'd7;
        wait_done(100, cyc);
        check("n3_latency", cyc, 32'd13);
        repeat (10) @(negedge clock);
        check("n3_count", terms.size(), 32'd3);
        if (terms.size() >= 3) begin
            check("n3_term0", {24'd0, terms[0]}, 32'd0);
            check("n3_term1", {24'd0, terms[1]}, 32'd1);
            check("n3_term2", {24'd0, terms[2]}, 32'd1);
        end
        check("n3_idle_busy", {31'd0, busy}, 32'd0);
        check_mem("n3", 8'd2, 8'd3, 8'd3);
        check("n3_ovf", {31'd0, overflow}, 32'd0);

        // Reset during WR_T1 of the second term
        preload(8'd1, 8'd2, 8'd0);
        start_seq(8'd2);
        hits = 0;
        for (int k = 0; k < 40 && hits < 2; k++) begin
            if (bus.MemWrite && bus.endereco == 8'd0) hits++;
            if (hits < 2) @(negedge clock);
        end
        check("abort_reach_wrt1", hits, 32'd2);
        reset_n = 1'b0;
        #1;
        check("abort_wr",    {31'd0, bus.MemWrite}, 32'd0);
        check("abort_addr",  {24'd0, bus.endereco}, 32'd0);
        check("abort_wdata", {24'd0, bus.dado_w},   32'd0);
        check("abort_busy",  {31'd0, busy},         32'd0);
        check("abort_term",  {24'd0, term},         32'd0);
        @(negedge clock);
        @(negedge clock);
        check_mem("abort", 8'd2, 8'd3, 8'd5);
        reset_n = 1'b1;
        terms.delete();
        start_seq(8'd1);
        wait_done(20, cyc);
        check("resume_count", terms.size(), 32'd1);
        if (terms.size() > 0) check("resume_term", {24'd0, terms[0]}, 32'd2);
        @(negedge clock);
        check_mem("resume", 8'd3, 8'd5, 8'd5);

        check("no_rd_wr_overlap", overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
